pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter mem_size, default 32, meaning the address width of all PC buses.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h00000000, meaning the first fetch address after reset.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port PC_out, input, mem_size, the current PC register value.
REQ-006 SHALL have port imem_ready, input, 1; high when instruction memory accepts a fetch this cycle.
REQ-007 SHALL have port load_use_stall, input, 1; hazard unit requests a fetch/decode freeze.
REQ-008 SHALL have port mispredict, input, 1, plus redirect_target, input, mem_size: EX-stage correction.
REQ-009 SHALL have port jal_valid, input, 1, plus jal_target, input, mem_size: ID-stage unconditional jump.
REQ-010 SHALL have port pred_taken, input, 1, plus pred_target, input, mem_size: YAGS predictor output for the fetch PC.
REQ-011 SHALL have port halt_req, input, 1 (ecall/ebreak retire), and resume, input, 1.
REQ-012 SHALL have port PC_write, output, 1, the PC register write enable.
REQ-013 SHALL have port jump_mux_out, output, mem_size, the next-PC value.
REQ-014 SHALL have ports if_id_write, if_id_flush, and id_ex_flush, each output, 1, controlling the pipeline registers.
REQ-015 SHALL have ports redirect_cnt and stall_cnt, each output, 16, performance counters.

Function
REQ-016 SHALL implement the FSM states BOOT, RUN, WAIT_MEM, and HALT.
REQ-017 BOOT SHALL last exactly one cycle with PC_write=1 and jump_mux_out=RESET_VECTOR, then go to RUN.
REQ-018 RUN next-PC priority SHALL be: pending redirect > mispredict (redirect_target) > load_use_stall (hold) > jal_valid (jal_target) > pred_taken (pred_target) > PC_out+4.
REQ-019 PC_out+4 SHALL be computed modulo 2^mem_size; 32'hFFFFFFFC SHALL wrap to 32'h00000000.
REQ-020 On mispredict in RUN with imem_ready=1, the block SHALL set PC_write=1, if_id_flush=1, and id_ex_flush=1 for that cycle only.
REQ-021 On mispredict, load_use_stall SHALL be ignored.
REQ-022 On load_use_stall without mispredict, the block SHALL set PC_write=0, if_id_write=0, and id_ex_flush=1.
REQ-023 On jal_valid without stall or mispredict, the block SHALL set PC_write=1, if_id_flush=1, and id_ex_flush=0.
REQ-024 In RUN with imem_ready=0, the block SHALL set PC_write=0 and if_id_write=0, and go to WAIT_MEM.
REQ-025 A mispredict seen with imem_ready=0 SHALL latch redirect_target into a pending register and assert both flushes in that cycle.
REQ-026 The pending register SHALL be overwritten by any later mispredict.
REQ-027 WAIT_MEM SHALL hold PC_write=0 until imem_ready=1, then apply the pending redirect if valid (PC_write=1, clear pending, go to RUN), else go to RUN with a normal RUN decision that cycle.
REQ-028 halt_req SHALL have lower priority than mispredict and higher priority than all other RUN events; it sets PC_write=0, if_id_flush=1, and enters HALT.
REQ-029 HALT SHALL hold PC_write=0 and if_id_write=0; resume with imem_ready=1 SHALL return to RUN with the next PC equal to PC_out+4.
REQ-030 A mispredict in HALT SHALL be latched as pending and applied on resume in preference to PC_out+4.
REQ-031 redirect_cnt SHALL increment on each cycle in which a redirect is applied to the PC.
REQ-032 stall_cnt SHALL increment on each cycle with PC_write=0 outside BOOT.
REQ-033 Both counters SHALL saturate at 16'hFFFF.
REQ-034 When PC_write=0, the block SHALL drive jump_mux_out=PC_out.
REQ-035 Outputs SHALL be combinational from state and inputs, with no added latency; a redirect takes effect on PC_out at the next rising edge.

Reset
REQ-036 While reset=1, asynchronously: state=BOOT, pending cleared, counters=0.
REQ-037 While reset=1, outputs SHALL be PC_write=0, jump_mux_out=RESET_VECTOR, if_id_write=0, and both flushes=1.
REQ-038 Reset asserted mid-WAIT_MEM or mid-HALT SHALL discard the pending redirect.

Verification
REQ-039 Reset release with imem_ready=1 and no events: PC_out sequence 0, 4, 8, 12; PC_write=1 every cycle after BOOT.
REQ-040 PC_out=0x40, mispredict=1, redirect_target=0x100, and load_use_stall=1 in the same cycle: PC_write=1, jump_mux_out=0x100, both flushes=1, redirect_cnt=1.
REQ-041 PC_out=0x20, imem_ready=0 for 3 cycles, mispredict pulse (target 0x80) in the 1st: PC_write=0 for 3 cycles, stall_cnt=3; first ready cycle gives jump_mux_out=0x80.
REQ-042 PC_out=0xFFFFFFFC with no events: jump_mux_out=0x00000000.
REQ-043 halt_req at PC_out=0x30, hold 5 cycles, then resume: PC frozen at 0x30; jump_mux_out=0x34 on the resume cycle.
REQ-044 Reset asserted during WAIT_MEM with a pending redirect to 0x200: after release, fetch restarts at 0x0 and 0x200 is never issued.

Source files
------------

// File: rtl/pc_sequencer.sv
// Next-PC sequencer: selects the fetch address from redirects, jumps, predictions
// and the sequential path, and steers the IF/ID and ID/EX pipeline registers.
module pc_sequencer #(
    parameter int                  mem_size     = 32,
    parameter logic [mem_size-1:0] RESET_VECTOR = 32'h00000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [mem_size-1:0] PC_out,
    input  logic                imem_ready,
    input  logic                load_use_stall,
    input  logic                mispredict,
    input  logic [mem_size-1:0] redirect_target,
    input  logic                jal_valid,
    input  logic [mem_size-1:0] jal_target,
    input  logic                pred_taken,
    input  logic [mem_size-1:0] pred_target,
    input  logic                halt_req,
    input  logic                resume,
    output logic                PC_write,
    output logic [mem_size-1:0] jump_mux_out,
    output logic                if_id_write,
    output logic                if_id_flush,
    output logic                id_ex_flush,
    output logic [15:0]         redirect_cnt,
    output logic [15:0]         stall_cnt
);

    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, WAIT_MEM = 2'd2, HALT = 2'd3} state_t;

    state_t              state_r, state_s;
    logic                pend_valid_r, pend_valid_s;
    logic [mem_size-1:0] pend_target_r, pend_target_s;
    logic [15:0]         redirect_cnt_r, stall_cnt_r;
    logic                pc_write_s, if_id_write_s, if_id_flush_s, id_ex_flush_s, redirect_s;
    logic [mem_size-1:0] next_pc_s, pc_plus4_s;

    assign pc_plus4_s = PC_out + mem_size'(3'd4);

    // State and pending-redirect registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= BOOT;
            pend_valid_r  <= 1'b0;
            pend_target_r <= {mem_size{1'b0}};
        end else begin
            state_r       <= state_s;
            pend_valid_r  <= pend_valid_s;
            pend_target_r <= pend_target_s;
        end
    end

    // Next-state, next-PC and pipeline-control decode
    always_comb begin
        state_s       = state_r;
        pend_valid_s  = pend_valid_r;
        pend_target_s = pend_target_r;
        pc_write_s    = 1'b0;
        next_pc_s     = PC_out;
        if_id_write_s = 1'b1;
        if_id_flush_s = 1'b0;
        id_ex_flush_s = 1'b0;
        redirect_s    = 1'b0;
        if (reset) begin
            next_pc_s     = RESET_VECTOR;
            if_id_write_s = 1'b0;
            if_id_flush_s = 1'b1;
            id_ex_flush_s = 1'b1;
            state_s       = BOOT;
            pend_valid_s  = 1'b0;
        end else begin
            case (state_r)
                BOOT: begin
                    pc_write_s    = 1'b1;
                    next_pc_s     = RESET_VECTOR;
                    if_id_flush_s = 1'b1;
                    id_ex_flush_s = 1'b1;
                    state_s       = RUN;
                end
                // WAIT_MEM re-evaluates the full RUN decision once memory is ready
                RUN, WAIT_MEM: begin
                    if (mispredict && !imem_ready) begin
                        if_id_write_s = 1'b0;
                        if_id_flush_s = 1'b1;
                        id_ex_flush_s = 1'b1;
                        pend_valid_s  = 1'b1;
                        pend_target_s = redirect_target;
                        state_s       = WAIT_MEM;
                    end else if (pend_valid_r) begin
                        if (imem_ready) begin
                            pc_write_s   = 1'b1;
                            next_pc_s    = pend_target_r;
                            pend_valid_s = 1'b0;
                            redirect_s   = 1'b1;
                            state_s      = RUN;
                        end else begin
                            if_id_write_s = 1'b0;
                            state_s       = WAIT_MEM;
                        end
                    end else if (mispredict) begin
                        pc_write_s    = 1'b1;
                        next_pc_s     = redirect_target;
                        if_id_flush_s = 1'b1;
                        id_ex_flush_s = 1'b1;
                        redirect_s    = 1'b1;
                        state_s       = RUN;
                    end else if (halt_req) begin
                        if_id_flush_s = 1'b1;
                        state_s       = HALT;
                    end else if (!imem_ready) begin
                        if_id_write_s = 1'b0;
                        state_s       = WAIT_MEM;
                    end else if (load_use_stall) begin
                        if_id_write_s = 1'b0;
                        id_ex_flush_s = 1'b1;
                        state_s       = RUN;
                    end else if (jal_valid) begin
                        pc_write_s    = 1'b1;
                        next_pc_s     = jal_target;
                        if_id_flush_s = 1'b1;
                        state_s       = RUN;
                    end else if (pred_taken) begin
                        pc_write_s = 1'b1;
                        next_pc_s  = pred_target;
                        state_s    = RUN;
                    end else begin
                        pc_write_s = 1'b1;
                        next_pc_s  = pc_plus4_s;
                        state_s    = RUN;
                    end
                end
                HALT: begin
                    if_id_write_s = 1'b0;
                    if_id_flush_s = mispredict;
                    id_ex_flush_s = mispredict;
                    if (resume && imem_ready) begin
                        pc_write_s    = 1'b1;
                        if_id_write_s = 1'b1;
                        pend_valid_s  = 1'b0;
                        state_s       = RUN;
                        if (pend_valid_r) begin
                            next_pc_s  = pend_target_r;
                            redirect_s = 1'b1;
                        end else if (mispredict) begin
                            next_pc_s  = redirect_target;
                            redirect_s = 1'b1;
                        end else begin
                            next_pc_s = pc_plus4_s;
                        end
                    end else if (mispredict) begin
                        pend_valid_s  = 1'b1;
                        pend_target_s = redirect_target;
                        state_s       = HALT;
                    end else begin
                        state_s = HALT;
                    end
                end
                default: begin
                    state_s      = BOOT;
                    pend_valid_s = 1'b0;
                end
            endcase
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redirect_cnt_r <= 16'h0000;
            stall_cnt_r    <= 16'h0000;
        end else begin
            if (redirect_s && (redirect_cnt_r != 16'hFFFF)) begin
                redirect_cnt_r <= redirect_cnt_r + 16'd1;
            end
            if (!pc_write_s && (state_r != BOOT) && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end
        end
    end

    assign PC_write     = pc_write_s;
    assign jump_mux_out = next_pc_s;
    assign if_id_write  = if_id_write_s;
    assign if_id_flush  = if_id_flush_s;
    assign id_ex_flush  = id_ex_flush_s;
    assign redirect_cnt = redirect_cnt_r;
    assign stall_cnt    = stall_cnt_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic
// compared against a priority-rule reference model and a bench-side PC register.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PC_out;
    logic        imem_ready, load_use_stall, mispredict, jal_valid, pred_taken;
    logic        halt_req, resume;
    logic [31:0] redirect_target, jal_target, pred_target;
    logic        PC_write, if_id_write, if_id_flush, id_ex_flush;
    logic [31:0] jump_mux_out;
    logic [15:0] redirect_cnt, stall_cnt;

    int errors = 0;
    int checks = 0;

    // reference model: boot flag, halted flag, pending-redirect queue (at most one entry)
    bit          m_boot, m_halt, n_boot, n_halt;
    logic [31:0] m_pend[$];
    logic [31:0] n_pend[$];
    int          m_rcnt, m_scnt;
    logic        e_pw, e_ifw, e_iff, e_idf;
    bit          e_redir;
    logic [31:0] e_nxt;

    pc_sequencer #(.mem_size(32), .RESET_VECTOR(32'h00000000)) dut (
        .clk(clk), .reset(reset), .PC_out(PC_out), .imem_ready(imem_ready),
        .load_use_stall(load_use_stall), .mispredict(mispredict),
        .redirect_target(redirect_target), .jal_valid(jal_valid), .jal_target(jal_target),
        .pred_taken(pred_taken), .pred_target(pred_target), .halt_req(halt_req),
        .resume(resume), .PC_write(PC_write), .jump_mux_out(jump_mux_out),
        .if_id_write(if_id_write), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void apply_redirect(input logic [31:0] tgt);
        e_pw    = 1'b1;
        e_nxt   = tgt;
        e_redir = 1'b1;
    endfunction

    // expected outputs and successor model state for the current inputs
    function automatic void model_outputs();
        e_pw = 1'b0; e_nxt = PC_out; e_ifw = 1'b1; e_iff = 1'b0; e_idf = 1'b0; e_redir = 1'b0;
        n_boot = 1'b0; n_halt = m_halt; n_pend = m_pend;
        if (reset) begin
            e_nxt = 32'h0; e_ifw = 1'b0; e_iff = 1'b1; e_idf = 1'b1;
            n_boot = 1'b1; n_halt = 1'b0; n_pend.delete();
        end else if (m_boot) begin
            e_pw = 1'b1; e_nxt = 32'h0; e_iff = 1'b1; e_idf = 1'b1;
        end else if (m_halt) begin
            e_ifw = 1'b0; e_iff = mispredict; e_idf = mispredict;
            if (resume && imem_ready) begin
                e_ifw = 1'b1; n_halt = 1'b0;
                if (m_pend.size() > 0) apply_redirect(m_pend[0]);
                else if (mispredict) apply_redirect(redirect_target);
                else begin e_pw = 1'b1; e_nxt = PC_out + 32'd4; end
                n_pend.delete();
            end else if (mispredict) begin
                n_pend.delete(); n_pend.push_back(redirect_target);
            end
        end else if (mispredict && !imem_ready) begin
            e_ifw = 1'b0; e_iff = 1'b1; e_idf = 1'b1;
            n_pend.delete(); n_pend.push_back(redirect_target);
        end else if (m_pend.size() > 0) begin
            if (imem_ready) begin apply_redirect(m_pend[0]); n_pend.delete(); end
            else e_ifw = 1'b0;
        end else if (mispredict) begin
            apply_redirect(redirect_target); e_iff = 1'b1; e_idf = 1'b1;
        end else if (halt_req) begin
            e_iff = 1'b1; n_halt = 1'b1;
        end else if (!imem_ready) begin
            e_ifw = 1'b0;
        end else if (load_use_stall) begin
            e_ifw = 1'b0; e_idf = 1'b1;
        end else if (jal_valid) begin
            e_pw = 1'b1; e_nxt = jal_target; e_iff = 1'b1;
        end else if (pred_taken) begin
            e_pw = 1'b1; e_nxt = pred_target;
        end else begin
            e_pw = 1'b1; e_nxt = PC_out + 32'd4;
        end
    endfunction

    function automatic void model_update();
        if (reset) begin
            m_rcnt = 0; m_scnt = 0;
        end else begin
            if (e_redir && m_rcnt < 65535) m_rcnt++;
            if (!m_boot && !e_pw && m_scnt < 65535) m_scnt++;
        end
        m_boot = n_boot; m_halt = n_halt; m_pend = n_pend;
    endfunction

    // one clock: compare combinational outputs, clock the PC register, compare counters
    task automatic step(input string tag);
        logic        cap_pw;
        logic [31:0] cap_nxt;
        #1;
        model_outputs();
        check({tag, ".PC_write"}, {31'd0, PC_write}, {31'd0, e_pw});
        check({tag, ".jump_mux_out"}, jump_mux_out, e_nxt);
        check({tag, ".if_id_write"}, {31'd0, if_id_write}, {31'd0, e_ifw});
        check({tag, ".if_id_flush"}, {31'd0, if_id_flush}, {31'd0, e_iff});
        check({tag, ".id_ex_flush"}, {31'd0, id_ex_flush}, {31'd0, e_idf});
        cap_pw  = PC_write;
        cap_nxt = jump_mux_out;
        @(posedge clk);
        #1;
        if (cap_pw === 1'b1 && !reset) PC_out = cap_nxt;
        model_update();
        check({tag, ".redirect_cnt"}, {16'd0, redirect_cnt}, 32'(m_rcnt));
        check({tag, ".stall_cnt"}, {16'd0, stall_cnt}, 32'(m_scnt));
        @(negedge clk);
    endtask

    task automatic quiet_inputs();
        imem_ready = 1'b1; load_use_stall = 1'b0; mispredict = 1'b0; jal_valid = 1'b0;
        pred_taken = 1'b0; halt_req = 1'b0; resume = 1'b0;
        redirect_target = 32'h0; jal_target = 32'h0; pred_target = 32'h0;
    endtask

    initial begin
        int base;
        m_boot = 1'b1; m_halt = 1'b0; m_rcnt = 0; m_scnt = 0;
        quiet_inputs();
        PC_out = 32'h0;
        reset  = 1'b1;
        @(negedge clk);
        step("reset");
        step("reset_hold");
        reset = 1'b0;
        step("boot");
        check("seq0", PC_out, 32'h0);
        step("seq_a");
        check("seq4", PC_out, 32'h4);
        step("seq_b");
        check("seq8", PC_out, 32'h8);
        step("seq_c");
        check("seq12", PC_out, 32'hC);

        // mispredict beats load-use stall
        PC_out = 32'h40; mispredict = 1'b1; redirect_target = 32'h100; load_use_stall = 1'b1;
        step("mp_vs_stall");
        check("mp_vs_stall.pc", PC_out, 32'h100);
        check("mp_vs_stall.cnt", {16'd0, redirect_cnt}, 32'd1);
        quiet_inputs();

        // mispredict during memory wait is held pending
        PC_out = 32'h20; imem_ready = 1'b0; mispredict = 1'b1; redirect_target = 32'h80;
        base = m_scnt;
        step("wait1");
        mispredict = 1'b0;
        step("wait2");
        step("wait3");
        check("wait.stall_cnt", {16'd0, stall_cnt}, 32'(base + 3));
        check("wait.pc_held", PC_out, 32'h20);
        imem_ready = 1'b1;
        step("wait_ready");
        check("wait.redirect", PC_out, 32'h80);

        // sequential wrap
        PC_out = 32'hFFFFFFFC;
        step("wrap");
        check("wrap.pc", PC_out, 32'h0);

        // halt and resume
        PC_out = 32'h30; halt_req = 1'b1;
        step("halt");
        halt_req = 1'b0;
        for (int i = 0; i < 5; i++) step("halted");
        check("halt.frozen", PC_out, 32'h30);
        resume = 1'b1;
        step("resume");
        check("resume.pc", PC_out, 32'h34);
        resume = 1'b0;

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            imem_ready      = ($urandom_range(0, 99) < 80);
            load_use_stall  = ($urandom_range(0, 99) < 20);
            mispredict      = ($urandom_range(0, 99) < 10);
            jal_valid       = ($urandom_range(0, 99) < 15);
            pred_taken      = ($urandom_range(0, 99) < 20);
            halt_req        = ($urandom_range(0, 99) < 3);
            resume          = ($urandom_range(0, 99) < 30);
            redirect_target = $urandom & 32'hFFFFFFFC;
            jal_target      = $urandom & 32'hFFFFFFFC;
            pred_target     = $urandom & 32'hFFFFFFFC;
            step("rand");
        end

        // reset during a pending redirect discards it
        quiet_inputs();
        resume = 1'b1;
        step("drain");
        resume = 1'b0;
        PC_out = 32'h20; imem_ready = 1'b0; mispredict = 1'b1; redirect_target = 32'h200;
        step("pend_set");
        mispredict = 1'b0;
        step("pend_wait");
        reset = 1'b1;
        step("pend_reset");
        reset = 1'b0; imem_ready = 1'b1;
        step("pend_boot");
        check("restart0", PC_out, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            step("restart");
            check("restart_seq", PC_out, 32'(4 * i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
